// File: rtl/ula_pkg.sv
// ula_pkg: types and constants shared by the ULA datapath and its command sequencer.
//   ula_op_e        ULA operation select (3 bits)
//   seq_state_e     sequencer FSM states
//   DIV_ZERO_RESULT result returned when a divide by zero is trapped
package ula_pkg;

    typedef enum logic [2:0] {
        ULA_ADD,
        ULA_SUB,
        ULA_MUL,
        ULA_DIV,
        ULA_AND,
        ULA_OR,
        ULA_NOT,
        ULA_PASSB
    } ula_op_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } seq_state_e;

    localparam logic [7:0] DIV_ZERO_RESULT = 8'hFF;

endpackage

// File: rtl/ula_sequencer.sv
// ula_sequencer: command front-end for the ULA datapath.
// Accepts one operation at a time over cmd_valid/cmd_ready, drives the ULA operand and
// control inputs, holds them for ALU_LAT edges, captures alu_c and returns it with zero
// and error flags over rsp_valid/rsp_ready. Divide by zero is trapped without waiting
// on the ULA.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op/shift/a/b         command fields
//   alu_a/b/op/shift         registered ULA drive
//   alu_c                    ULA result
//   rsp_valid/rsp_ready      response handshake
//   rsp_data/zero/err        captured result and flags
//   busy                     FSM not idle
//   op_count                 completed responses, wrapping
module ula_sequencer
    import ula_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  ula_op_e           cmd_op,
    input  logic              cmd_shift,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output ula_op_e           alu_op,
    output logic              alu_shift,
    input  logic [DATA_W-1:0] alu_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [2:0] LatInit = 3'(ALU_LAT);

    seq_state_e        state_q, state_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    ula_op_e           alu_op_q, alu_op_d;
    logic              alu_shift_q, alu_shift_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ULA_ADD;
            alu_shift_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_shift_q <= alu_shift_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
            op_count_q  <= op_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_shift_d = alu_shift_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        op_count_d  = op_count_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // Operands are latched even for a trapped divide so alu_* always
                    // reflect the last accepted command.
                    alu_a_d     = cmd_a;
                    alu_b_d     = cmd_b;
                    alu_op_d    = cmd_op;
                    alu_shift_d = cmd_shift;
                    if (cmd_op == ULA_DIV && cmd_b == '0) begin
                        rsp_data_d = DATA_W'(DIV_ZERO_RESULT);
                        rsp_zero_d = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = DONE;
                    end else begin
                        lat_cnt_d = LatInit;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q != 3'd0) begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end else begin
                    rsp_data_d = alu_c;
                    rsp_zero_d = (alu_c == '0);
                    rsp_err_d  = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_shift = alu_shift_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_ula_sequencer.sv
// tb_ula_sequencer: directed plus randomized bench for ula_sequencer with a registered
// ULA model of ALU_LAT edges and a small counter width so op_count wrap is reached.
module tb_ula_sequencer;
    import ula_pkg::*;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ALU_LAT = 3;
    localparam int unsigned CNT_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    ula_op_e           cmd_op = ULA_ADD;
    logic              cmd_shift = 1'b0;
    logic [DATA_W-1:0] cmd_a = '0;
    logic [DATA_W-1:0] cmd_b = '0;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    ula_op_e           alu_op;
    logic              alu_shift;
    logic [DATA_W-1:0] alu_c;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic              rsp_err;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] model_count = '0;

    ula_sequencer #(
        .DATA_W (DATA_W),
        .ALU_LAT(ALU_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_shift(cmd_shift),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_shift(alu_shift),
        .alu_c    (alu_c),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_zero (rsp_zero),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    // Architectural result of an operation, including the trapped divide.
    function automatic logic [7:0] ref_result(input ula_op_e op, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            ULA_ADD:   return a + b;
            ULA_SUB:   return a - b;
            ULA_MUL:   return p[7:0];
            ULA_DIV:   return (b == 8'd0) ? 8'hFF : a / b;
            ULA_AND:   return a & b;
            ULA_OR:    return a | b;
            ULA_NOT:   return ~a;
            default:   return b;
        endcase
    endfunction

    // The ULA itself returns 0 on divide by zero, so an untrapped issue would be visible.
    function automatic logic [7:0] ula_fn(input ula_op_e op, input logic [7:0] a,
                                          input logic [7:0] b);
        if (op == ULA_DIV && b == 8'd0) return 8'h00;
        return ref_result(op, a, b);
    endfunction

    logic [7:0] ula_pipe [ALU_LAT];
    always @(posedge clk) begin
        ula_pipe[0] <= ula_fn(alu_op, alu_a, alu_b);
        for (int i = 1; i < int'(ALU_LAT); i++) ula_pipe[i] <= ula_pipe[i-1];
    end
    assign alu_c = ula_pipe[ALU_LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input ula_op_e op, input logic sh, input logic [7:0] a,
                         input logic [7:0] b, input int hold);
        int         n;
        logic       exp_err;
        logic [7:0] exp_d;
        int         exp_lat;
        logic       stable;
        exp_err = (op == ULA_DIV) && (b == 8'd0);
        exp_d   = ref_result(op, a, b);
        exp_lat = exp_err ? 0 : int'(ALU_LAT) + 1;

        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_shift = sh;
        cmd_a     = a;
        cmd_b     = b;
        step();
        cmd_valid = 1'b0;
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_op    = ula_op_e'($urandom_range(0, 7));
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        check("alu_a", {24'd0, alu_a}, {24'd0, a});
        check("alu_b", {24'd0, alu_b}, {24'd0, b});
        check("alu_op", {29'd0, alu_op}, {29'd0, op});
        check("alu_shift", {31'd0, alu_shift}, {31'd0, sh});

        n = 0;
        stable = 1'b1;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
            if (alu_a !== a || alu_b !== b || alu_op !== op || alu_shift !== sh) stable = 1'b0;
        end
        check("rsp_latency", n, exp_lat);
        check("alu_stable_wait", {31'd0, stable}, 32'd1);

        // Backpressure with a competing command offered; it must not be accepted.
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = ~a;
            step();
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_data", {24'd0, rsp_data}, {24'd0, exp_d});
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("bp_alu_a", {24'd0, alu_a}, {24'd0, a});
        end
        cmd_valid = 1'b0;

        check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_d});
        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, (exp_d == 8'd0) && !exp_err});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        rsp_ready = 1'b1;
        step();
        rsp_ready   = 1'b0;
        model_count = model_count + 1'b1;
        check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        check("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        check("op_count", {28'd0, op_count}, {28'd0, model_count});
        check("alu_a_kept", {24'd0, alu_a}, {24'd0, a});
    endtask

    initial begin
        // Reset state.
        step();
        step();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_op_count", {28'd0, op_count}, 32'd0);
        check("rst_alu_a", {24'd0, alu_a}, 32'd0);
        rst = 1'b0;
        step();

        do_op(ULA_ADD, 1'b0, 8'd20, 8'd22, 0);
        do_op(ULA_SUB, 1'b1, 8'h05, 8'h05, 0);
        do_op(ULA_DIV, 1'b0, 8'd9, 8'd0, 1);
        do_op(ULA_MUL, 1'b0, 8'd3, 8'd4, 5);
        do_op(ULA_DIV, 1'b1, 8'd200, 8'd7, 0);

        // Asynchronous reset while in WAIT discards the operation.
        cmd_valid = 1'b1;
        cmd_op    = ULA_ADD;
        cmd_a     = 8'd1;
        cmd_b     = 8'd2;
        step();
        cmd_valid = 1'b0;
        step();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_op_count", {28'd0, op_count}, 32'd0);
        check("arst_alu_a", {24'd0, alu_a}, 32'd0);
        check("arst_rsp_data", {24'd0, rsp_data}, 32'd0);
        model_count = '0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        do_op(ULA_AND, 1'b0, 8'hF0, 8'h3C, 0);

        // Random traffic; enough completions to wrap the narrow op_count.
        for (int i = 0; i < 24; i++) begin
            ula_op_e    op;
            logic [7:0] a;
            logic [7:0] b;
            op = ula_op_e'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            do_op(op, 1'($urandom), a, b, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
